mem_responder: RTL and testbench
================================

# mem_responder

Synthesizable memory-side responder for the tagged `MEM_COMMAND` bus that the accelerator's memory controller drives. It accepts one load or store per cycle and returns a transaction tag in the same cycle. For loads, it returns the block data with the matching data tag a fixed number of cycles later. It backs a block-addressed storage array and serves as the memory endpoint for integration simulation and FPGA bring-up of the Q/K/V load and O drain phases.

## Interface
Parameters:
- `MEM_DEPTH_BLOCKS`, default 4096: number of 8-byte blocks in the array.
- `LATENCY`, default 4: cycles from command accept to data response. Legal range is 1 to `NUM_MEM_TAGS`-2.
- `ADDR_OFFSET`, default `'h0`: byte address subtracted before indexing.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `proc2mem_command`, in, `MEM_COMMAND`: `MEM_NONE`, `MEM_LOAD` or `MEM_STORE`.
- `proc2mem_addr`, in, `ADDR`: byte address.
- `proc2mem_data`, in, `MEM_BLOCK`: store data.
- `mem2proc_transaction_tag`, out, `MEM_TAG`: tag assigned to this cycle's command. 0 means no command or rejected.
- `mem2proc_data`, out, `MEM_BLOCK`: load data. It is `'0` when `mem2proc_data_tag` is 0 or the response is a store ack.
- `mem2proc_data_tag`, out, `MEM_TAG`: tag of the transaction completing this cycle. 0 means none.

## Operation
- **Block index:** `(proc2mem_addr - ADDR_OFFSET) >> 3`, modulo `MEM_DEPTH_BLOCKS`. Address bits [2:0] are ignored, so a misaligned address hits the containing block.
- **Tags:** legal tags are 1 to `NUM_MEM_TAGS`-1. Each tag has one pending slot holding valid, is_load, countdown and snapshot data.
- **Accept:** a `MEM_LOAD`, or a `MEM_STORE` under ack mode, is accepted when at least one slot is free.
  - The lowest-numbered free tag is allocated.
  - That tag is driven combinationally on `mem2proc_transaction_tag` in the same cycle.
  - At the clock edge, the slot is set with countdown `LATENCY`.
- **Load:** the block is read into the slot's snapshot at the accept edge, so later stores do not alter an outstanding load.
- **Store:** the block is written at the accept edge. A load accepted in the next cycle returns the new data.
- **Reject:** when no tag is free, `mem2proc_transaction_tag`=0 and the command has no effect. In particular, the store is not written. The initiator must retry.
- **Countdown:** every valid slot decrements once per cycle.
  - A slot reaching 0 drives its tag on `mem2proc_data_tag`, with the snapshot on `mem2proc_data` (loads) or `'0` (store acks).
  - The slot is then freed.
- **One response per cycle:** at most one command is accepted per cycle and latency is fixed, so at most one slot expires per cycle. More than one expiring slot is an assertion failure.
- **Tag reuse:** a tag freed in cycle N is allocatable from cycle N+1. It is not allocatable in the cycle N in which it is emitted.
- **Illegal commands:** any command encoding other than the three listed is treated as `MEM_NONE`.

## Timing
- **Transaction tag:** combinational from `proc2mem_command` and slot state.
- **Response:** a command accepted in cycle N has its response visible during cycle N+`LATENCY`. `mem2proc_data` and `mem2proc_data_tag` are registered outputs.
- **Throughput:** one command per cycle, sustained indefinitely, since `LATENCY` < `NUM_MEM_TAGS`-1 guarantees a free tag.
- **Reset (`rst`=1):**
  - All slots are cleared.
  - `mem2proc_data_tag`=0 and `mem2proc_data`='0 in the cycle after the reset edge.
  - `mem2proc_transaction_tag`=0 while `rst` is high.
  - Array contents are retained.
  - Reset in the middle of a transaction drops all outstanding responses. No stale tag ever appears after reset.
- **Back-to-back:** a load to address A in cycle N+1, following a store to A in cycle N, returns the stored data in cycle N+1+`LATENCY`.

## Configuration
- **Macro `MEM_RESP_STORE_ACK_EN`:**
  - **Defined:** stores allocate a tag and return a completion pulse on `mem2proc_data_tag` after `LATENCY` cycles, with data `'0`. The controller uses this as write confirmation for the O drain phase.
  - **Undefined:** stores are fire-and-forget. They always return `mem2proc_transaction_tag`=0, never occupy a slot, never generate a data tag, and are always written.

## Structure
- **Existing shared types:** `MEM_TAG`, `MEM_BLOCK`, `MEM_COMMAND`, `ADDR`, `NUM_MEM_TAGS` and `MEM_BLOCK_SIZE_BYTES` stay in the shared definitions package.
- **New package entry:** `MEM_RESP_SLOT_T` (struct: valid, is_load, countdown, data) is added to that package.
- **Sub-module `mem_resp_tag_alloc`:** a combinational lowest-free-tag priority encoder over the slot valid bits. It outputs the tag and a found flag.

## Test plan
- **Single load:** after reset, store `64'hDEAD_BEEF` to `'h1000`, then issue a load from `'h1000` in cycle 10. Expect `mem2proc_transaction_tag`=1 in cycle 10, and `mem2proc_data_tag`=1 with data `64'hDEAD_BEEF` in cycle 10+`LATENCY`.
- **Streaming:** issue 32 consecutive loads of `'h2000`+8i with `LATENCY`=4. Expect tags to cycle 1..5 then repeat, with no zeros, and responses in order with data matching the preloaded pattern.
- **Exhaustion:** set `LATENCY`=`NUM_MEM_TAGS`-2 and drive loads every cycle. Expect no rejection. Then force a slot stall via a bind stub, and expect tag 0 and no array write for a store issued while full.
- **Snapshot:** load A in cycle N, then store a new value to A in cycle N+1. Expect the load response to carry the old value. A load of A in cycle N+2 returns the new value.
- **Reset mid-flight:** issue 3 loads, then assert `rst` for one cycle before any response. Expect `mem2proc_data_tag`=0 for the next 2×`LATENCY` cycles, and the next load gets tag 1.
- **Store ack:** store to `'h4000`.
  - With `MEM_RESP_STORE_ACK_EN`: expect a nonzero tag, then the same tag on `mem2proc_data_tag` with data `'0` after `LATENCY` cycles.
  - Without it: expect tag 0, no pulse, and data readable afterwards.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared memory-bus definitions plus the responder's pending-slot record.
package mem_responder_pkg;

  localparam int NUM_MEM_TAGS         = 15;
  localparam int MEM_BLOCK_SIZE_BYTES = 8;
  localparam int MEM_CNT_W            = $clog2(NUM_MEM_TAGS);

  typedef logic [3:0]  MEM_TAG;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [31:0] ADDR;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef struct packed {
    logic                 valid;
    logic                 is_load;
    logic [MEM_CNT_W-1:0] countdown;
    MEM_BLOCK             data;
  } MEM_RESP_SLOT_T;

endpackage

// File: rtl/mem_resp_tag_alloc.sv
// Lowest-free-tag priority encoder; bit i of busy corresponds to tag i+1.
module mem_resp_tag_alloc
  import mem_responder_pkg::*;
(
  input  logic [NUM_MEM_TAGS-2:0] busy,
  output MEM_TAG                  tag,
  output logic                    found
);

  always_comb begin
    tag   = '0;
    found = 1'b0;
    for (int t = NUM_MEM_TAGS - 1; t >= 1; t--) begin
      if (!busy[t-1]) begin
        tag   = MEM_TAG'(t);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Tagged memory-side responder with fixed-latency load responses.
// Optional store acknowledge: define MEM_RESP_STORE_ACK_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int  MEM_DEPTH_BLOCKS = 4096,
  parameter int  LATENCY          = 4,
  parameter ADDR ADDR_OFFSET      = 'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  MEM_COMMAND proc2mem_command,
  input  ADDR        proc2mem_addr,
  input  MEM_BLOCK   proc2mem_data,
  output MEM_TAG     mem2proc_transaction_tag,
  output MEM_BLOCK   mem2proc_data,
  output MEM_TAG     mem2proc_data_tag
);

  localparam int IDX_W = $clog2(MEM_DEPTH_BLOCKS);

  MEM_BLOCK       mem [MEM_DEPTH_BLOCKS];
  MEM_RESP_SLOT_T slot     [1:NUM_MEM_TAGS-1];
  MEM_RESP_SLOT_T slot_nxt [1:NUM_MEM_TAGS-1];

  logic [NUM_MEM_TAGS-2:0] busy;
  MEM_TAG                  free_tag;
  logic                    found;
  ADDR                     blk_mod;
  logic [IDX_W-1:0]        idx;
  logic                    unused_blk_bits;
  MEM_BLOCK                rd_data;
  logic                    is_ld, is_st, want_slot, accept, st_write;
  MEM_TAG                  emit_tag;
  MEM_BLOCK                emit_data;
  logic [3:0]              exp_cnt;

  assign blk_mod         = ((proc2mem_addr - ADDR_OFFSET) >> 3) % ADDR'(MEM_DEPTH_BLOCKS);
  assign idx             = blk_mod[IDX_W-1:0];
  assign unused_blk_bits = ^blk_mod[$bits(ADDR)-1:IDX_W];
  assign rd_data         = mem[idx];

  always_comb begin
    for (int t = 1; t < NUM_MEM_TAGS; t++) busy[t-1] = slot[t].valid;
  end

  mem_resp_tag_alloc u_alloc (
    .busy  (busy),
    .tag   (free_tag),
    .found (found)
  );

  assign is_ld = (proc2mem_command == MEM_LOAD);
  assign is_st = (proc2mem_command == MEM_STORE);

`ifdef MEM_RESP_STORE_ACK_EN
  assign want_slot = is_ld | is_st;
  assign st_write  = is_st & found & ~rst;
`else
  assign want_slot = is_ld;
  assign st_write  = is_st & ~rst;
`endif

  assign accept                   = want_slot & found & ~rst;
  assign mem2proc_transaction_tag = accept ? free_tag : '0;

  // Slot update: a slot showing countdown 1 is in its emission cycle and is freed at the next edge
  always_comb begin
    slot_nxt = slot;
    for (int t = 1; t < NUM_MEM_TAGS; t++) begin
      if (slot[t].valid) begin
        slot_nxt[t].countdown = slot[t].countdown - MEM_CNT_W'(1);
        if (slot[t].countdown == MEM_CNT_W'(1)) slot_nxt[t].valid = 1'b0;
      end
    end
    if (accept) begin
      slot_nxt[free_tag].valid     = 1'b1;
      slot_nxt[free_tag].is_load   = is_ld;
      slot_nxt[free_tag].countdown = MEM_CNT_W'(LATENCY);
      slot_nxt[free_tag].data      = is_ld ? rd_data : '0;
    end
  end

  always_comb begin
    emit_tag  = '0;
    emit_data = '0;
    exp_cnt   = '0;
    for (int t = 1; t < NUM_MEM_TAGS; t++) begin
      if (slot_nxt[t].valid && slot_nxt[t].countdown == MEM_CNT_W'(1)) begin
        emit_tag  = MEM_TAG'(t);
        emit_data = slot_nxt[t].is_load ? slot_nxt[t].data : '0;
        exp_cnt   = exp_cnt + 4'd1;
      end
    end
  end

  // Registered stage: slot state, array write, response outputs
  always_ff @(posedge clk) begin
    for (int t = 1; t < NUM_MEM_TAGS; t++) begin
      slot[t] <= slot_nxt[t];
      if (rst) slot[t].valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (st_write) mem[idx] <= proc2mem_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem2proc_data_tag <= '0;
      mem2proc_data     <= '0;
    end else begin
      mem2proc_data_tag <= emit_tag;
      mem2proc_data     <= emit_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (exp_cnt <= 4'd1);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard of expected responses plus a tag-allocation model.
`timescale 1ns/1ps
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT   = 4;
  localparam int LAT_B = NUM_MEM_TAGS - 2;

  logic       clk = 1'b0;
  logic       rst;
  MEM_COMMAND cmd, cmd_b;
  ADDR        addr, addr_b;
  MEM_BLOCK   wdata, wdata_b;
  MEM_TAG     ttag, dtag, ttag_b, dtag_b;
  MEM_BLOCK   rdata, rdata_b;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_transaction_tag(ttag),
    .mem2proc_data(rdata), .mem2proc_data_tag(dtag)
  );

  mem_responder #(.LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .proc2mem_command(cmd_b), .proc2mem_addr(addr_b),
    .proc2mem_data(wdata_b), .mem2proc_transaction_tag(ttag_b),
    .mem2proc_data(rdata_b), .mem2proc_data_tag(dtag_b)
  );

  typedef struct {
    MEM_TAG   tag;
    MEM_BLOCK data;
    int       due;
  } exp_t;

  exp_t     sb[$];
  int       busy_until [1:NUM_MEM_TAGS-1];
  MEM_BLOCK model [int];
  int       errors = 0;
  int       checks = 0;
  int       cyc = 0;
  bit       mon_en = 1'b0;
  MEM_TAG   last_tag;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        assert (dtag === sb[0].tag && rdata === sb[0].data) else begin
          errors++;
          $error("FAIL resp cyc=%0d got tag=%0d data=%h, expected tag=%0d data=%h",
                 cyc, dtag, rdata, sb[0].tag, sb[0].data);
        end
        void'(sb.pop_front());
      end else begin
        assert (dtag === 4'd0 && rdata === 64'd0) else begin
          errors++;
          $error("FAIL idle cyc=%0d got tag=%0d data=%h, expected tag=0 data=0", cyc, dtag, rdata);
        end
      end
    end
  end

  function automatic MEM_TAG pred_tag();
    for (int t = 1; t < NUM_MEM_TAGS; t++)
      if (busy_until[t] < cyc) return MEM_TAG'(t);
    return '0;
  endfunction

  function automatic MEM_BLOCK rd_model(int idx);
    return model.exists(idx) ? model[idx] : '0;
  endfunction

  task automatic clear_model_tags();
    for (int t = 1; t < NUM_MEM_TAGS; t++) busy_until[t] = -1;
  endtask

  task automatic idle();
    cmd = MEM_NONE;
    @(posedge clk); #1;
  endtask

  task automatic issue(MEM_COMMAND c, ADDR a, MEM_BLOCK d);
    MEM_TAG exp;
    int     idx;
    bit     wants;
    cmd   = c;
    addr  = a;
    wdata = d;
    idx   = int'((a >> 3) % 32'd4096);
    wants = (c == MEM_LOAD);
`ifdef MEM_RESP_STORE_ACK_EN
    wants = wants || (c == MEM_STORE);
`endif
    exp = wants ? pred_tag() : '0;
    @(negedge clk);
    last_tag = ttag;
    checks++;
    assert (ttag === exp) else begin
      errors++;
      $error("FAIL txn_tag cyc=%0d got=%0d expected=%0d", cyc, ttag, exp);
    end
    if (exp != 0) begin
      busy_until[exp] = cyc + LAT;
      sb.push_back('{tag: exp, data: (c == MEM_LOAD) ? rd_model(idx) : '0, due: cyc + LAT});
    end
    if (c == MEM_STORE && (!wants || exp != 0)) model[idx] = d;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int budget = 60;
    while (sb.size() > 0 && budget > 0) begin
      idle();
      budget--;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain timeout pending=%0d expected=0", sb.size());
    end
    idle();
  endtask

  task automatic check_tag(string name, MEM_TAG got, MEM_TAG want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  initial begin
    rst = 1'b1; cmd = MEM_NONE; cmd_b = MEM_NONE;
    addr = '0; wdata = '0; addr_b = '0; wdata_b = '0;
    clear_model_tags();
    repeat (3) begin @(posedge clk); #1; end
    cmd = MEM_LOAD; cmd_b = MEM_LOAD;
    @(negedge clk);
    check_tag("reset_txn_tag", ttag, 4'd0);
    check_tag("reset_txn_tag_b", ttag_b, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0; cmd = MEM_NONE; cmd_b = MEM_NONE;
    mon_en = 1'b1;
    @(negedge clk);
    check_tag("reset_data_tag", dtag, 4'd0);
    @(posedge clk); #1;

    // Single load at cycle 10
    issue(MEM_STORE, 32'h1000, 64'hDEAD_BEEF);
    while (cyc < 10) idle();
    issue(MEM_LOAD, 32'h1000, '0);
    check_tag("single_load_tag", last_tag, 4'd1);
    issue(MEM_LOAD, 32'h1003, '0);
    drain();

    // Streaming
    for (int i = 0; i < 32; i++)
      issue(MEM_STORE, 32'h2000 + 32'(8 * i), {32'hA5A5_0000 + 32'(i), 32'(i * 7 + 3)});
    drain();
    for (int i = 0; i < 32; i++) begin
      issue(MEM_LOAD, 32'h2000 + 32'(8 * i), '0);
      check_tag("stream_tag", last_tag, MEM_TAG'((i % 5) + 1));
    end
    drain();

    // Snapshot and back-to-back
    issue(MEM_STORE, 32'h3000, 64'h1111_1111_1111_1111);
    drain();
    issue(MEM_LOAD,  32'h3000, '0);
    issue(MEM_STORE, 32'h3000, 64'h2222_2222_2222_2222);
    issue(MEM_LOAD,  32'h3000, '0);
    issue(MEM_STORE, 32'h3008, 64'h0123_4567_89AB_CDEF);
    issue(MEM_LOAD,  32'h3008, '0);
    drain();

    // Illegal encoding behaves as no command
    issue(MEM_COMMAND'(2'b11), 32'h1000, 64'hBAD0_BAD0_BAD0_BAD0);
    issue(MEM_LOAD, 32'h1000, '0);
    drain();

    // Reset with outstanding loads
    issue(MEM_LOAD, 32'h2000, '0);
    issue(MEM_LOAD, 32'h2008, '0);
    issue(MEM_LOAD, 32'h2010, '0);
    rst = 1'b1; cmd = MEM_LOAD;
    @(negedge clk);
    check_tag("midreset_txn_tag", ttag, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0; cmd = MEM_NONE;
    sb.delete();
    clear_model_tags();
    repeat (2 * LAT) idle();
    issue(MEM_LOAD, 32'h1000, '0);
    check_tag("post_reset_tag", last_tag, 4'd1);
    drain();

    // Store acknowledge / fire-and-forget
    issue(MEM_STORE, 32'h4000, 64'hCAFE_F00D_0000_4000);
`ifdef MEM_RESP_STORE_ACK_EN
    checks++;
    assert (last_tag !== 4'd0) else begin
      errors++;
      $error("FAIL store_ack_tag got=%0d expected=nonzero", last_tag);
    end
`endif
    drain();
    issue(MEM_LOAD, 32'h4000, '0);
    drain();

    // Deepest legal latency: every cycle must get a tag
    for (int i = 0; i < 30; i++) begin
      cmd_b = MEM_LOAD;
      @(negedge clk);
      check_tag("deep_lat_tag", ttag_b, MEM_TAG'((i % (LAT_B + 1)) + 1));
      @(posedge clk); #1;
    end
    cmd_b = MEM_NONE;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
